// File: rtl/alu_result_formatter_if.sv
// ============================================================================
// alu_result_formatter_if : conversion request / BCD result / display bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_result_formatter_if;
  logic       start;
  logic [7:0] result;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic       sign;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output start, result, signed_mode,
    input  busy, done, sign, bcd_hund, bcd_tens, bcd_ones, seg, an
  );

  modport slave (
    input  start, result, signed_mode,
    output busy, done, sign, bcd_hund, bcd_tens, bcd_ones, seg, an
  );
endinterface

`default_nettype wire

// File: rtl/alu_result_formatter.sv
// ============================================================================
// alu_result_formatter : 8-bit result -> sign + 3 BCD digits (double dabble),
// optional multiplexed seven-segment scan when FMT_SEG_SCAN_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_result_formatter #(
  parameter int SCAN_DIV_W = 17
) (
  input  wire logic             clk,
  input  wire logic             rst,
  alu_result_formatter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mag_q,   mag_d;
  logic [11:0] work_q,  work_d;
  logic [3:0]  iter_q,  iter_d;
  logic        neg_q,   neg_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        sign_q,  sign_d;
  logic [3:0]  hund_q,  hund_d;
  logic [3:0]  tens_q,  tens_d;
  logic [3:0]  ones_q,  ones_d;

  logic [11:0] adj;
  logic [19:0] shifted;
  logic [3:0]  nib;

  always_comb begin
    adj = work_q;
    nib = 4'd0;
    for (int i = 0; i < 3; i++) begin
      nib             = work_q[4*i +: 4];
      adj[4*i +: 4]   = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    shifted = {adj, mag_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    work_d  = work_q;
    iter_d  = iter_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.signed_mode && bus.result[7]) begin
            mag_d = ~bus.result + 8'd1;
            neg_d = 1'b1;
          end else begin
            mag_d = bus.result;
            neg_d = 1'b0;
          end
          work_d  = 12'd0;
          iter_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        work_d = shifted[19:8];
        mag_d  = shifted[7:0];
        iter_d = iter_q + 4'd1;
        // Final shift: publish straight from the shifter so done lines up with DONE
        if (iter_q == 4'd7) begin
          hund_d  = shifted[19:16];
          tens_d  = shifted[15:12];
          ones_d  = shifted[11:8];
          sign_d  = neg_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= 8'd0;
      work_q  <= 12'd0;
      iter_q  <= 4'd0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sign     = sign_q;
  assign bus.bcd_hund = hund_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;

  if (SCAN_DIV_W < 2) begin : g_div_w_check
    $error("SCAN_DIV_W must be at least 2");
  end

`ifdef FMT_SEG_SCAN_EN
  logic [SCAN_DIV_W-1:0] scan_q, scan_d;
  logic [6:0]            seg_q,  seg_d;
  logic [3:0]            an_q,   an_d;
  logic [1:0]            digit_sel;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign digit_sel = scan_q[SCAN_DIV_W-1 -: 2];

  // Leading-zero blanking: hundreds/tens go dark when no higher digit is lit
  always_comb begin
    scan_d = scan_q + 1'b1;
    seg_d  = 7'h7F;
    an_d   = 4'hF;
    case (digit_sel)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg7(ones_q);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? 7'h7F : seg7(tens_q);
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = (hund_q == 4'd0) ? 7'h7F : seg7(hund_q);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = sign_q ? 7'b0111111 : 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      seg_q  <= 7'h7F;
      an_q   <= 4'hF;
    end else begin
      scan_q <= scan_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
`else
  assign bus.seg = 7'h7F;
  assign bus.an  = 4'hF;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_formatter.sv
// ============================================================================
// tb_alu_result_formatter : directed checks of conversion, latency, start
// filtering, reset abort and the display outputs (scan or tied-off build).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_formatter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_formatter_if bus ();

  alu_result_formatter #(.SCAN_DIV_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion; optional stray start (with new operands) and optional reset in cycle k
  task automatic run(input string tag, input logic [7:0] res, input logic sm,
                     input int glitch_k, input int rst_k,
                     input logic [3:0] eh, input logic [3:0] et, input logic [3:0] eo,
                     input logic es);
    int first;
    int nd;
    logic exp_busy;
    first = 0;
    nd    = 0;
    bus.result      = res;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      bus.start = (k == glitch_k);
      if (k == glitch_k) begin
        bus.result      = 8'hC8;
        bus.signed_mode = ~sm;
      end
      rst = (k == rst_k);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        if (first == 0) first = k;
      end
      exp_busy = (rst_k != 0) ? (k <= rst_k) : (k <= 9);
      check($sformatf("%s busy c%0d", tag, k), {31'd0, bus.busy}, {31'd0, exp_busy});
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    check({tag, " done_cycle"}, first, (rst_k != 0) ? 0 : 9);
    check({tag, " done_count"}, nd,    (rst_k != 0) ? 0 : 1);
    check({tag, " sign"}, {31'd0, bus.sign}, {31'd0, es});
    check({tag, " digits"}, {20'd0, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones},
          {20'd0, eh, et, eo});
  endtask

`ifdef FMT_SEG_SCAN_EN
  logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_exp[4] = '{7'b1000000, 7'b1111001, 7'h7F, 7'b0111111};
`endif

  initial begin
    int guard;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.result      = 8'h00;
    bus.signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst sign", {31'd0, bus.sign}, 32'd0);
    check("rst digits", {20'd0, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, 32'd0);
    check("rst seg", {25'd0, bus.seg}, 32'h7F);
    check("rst an", {28'd0, bus.an}, 32'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run("u_ff",   8'hFF, 1'b0, 0, 0, 4'd2, 4'd5, 4'd5, 1'b0);
    run("s_ff",   8'hFF, 1'b1, 0, 0, 4'd0, 4'd0, 4'd1, 1'b1);
    run("s_80",   8'h80, 1'b1, 0, 0, 4'd1, 4'd2, 4'd8, 1'b1);
    run("abort",  8'h2A, 1'b0, 0, 4, 4'd0, 4'd0, 4'd0, 1'b0);
    run("s_7f",   8'h7F, 1'b1, 0, 0, 4'd1, 4'd2, 4'd7, 1'b0);
    run("glitch", 8'h05, 1'b0, 3, 0, 4'd0, 4'd0, 4'd5, 1'b0);
    run("u_2a",   8'h2A, 1'b0, 0, 0, 4'd0, 4'd4, 4'd2, 1'b0);

    // Reset and start together: reset wins, outputs clear, no conversion begins
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.result = 8'h63;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_vs_start busy", {31'd0, bus.busy}, 32'd0);
    check("rst_vs_start digits", {20'd0, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, 32'd0);
    @(posedge clk); #1;

    run("s_f6", 8'hF6, 1'b1, 0, 0, 4'd0, 4'd1, 4'd0, 1'b1);

`ifdef FMT_SEG_SCAN_EN
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.an !== 4'b0111 && guard < 64);
    do begin
      @(negedge clk);
      guard++;
    end while (bus.an !== 4'b1110 && guard < 64);
    check("scan sync", {31'd0, guard < 64}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("scan an %0d", i),  {28'd0, bus.an},  {28'd0, an_exp[i/4]});
      check($sformatf("scan seg %0d", i), {25'd0, bus.seg}, {25'd0, seg_exp[i/4]});
    end
`else
    guard = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("tied seg %0d", i), {25'd0, bus.seg}, 32'h7F);
      check($sformatf("tied an %0d", i),  {28'd0, bus.an},  32'hF);
      guard++;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
